// File: rtl/rt_prog_cnt_pkg.sv
// rt_cnt_pkg: shared constants for the programmable event counter.
//   DIR_UP/DIR_DN     encoding of rt_i_dir
//   MODE_WRAP/SAT     values of the SAT_MODE parameter
//   rt_params_ok()    legal-range check for CW/PW/SAT_MODE, used at elaboration
package rt_cnt_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;

    localparam int   CW_MIN    = 2;
    localparam int   CW_MAX    = 64;
    localparam int   PW_MIN    = 1;
    localparam int   PW_MAX    = 16;

    function automatic bit rt_params_ok(input int cw, input int pw, input int mode);
        return (cw >= CW_MIN) && (cw <= CW_MAX) &&
               (pw >= PW_MIN) && (pw <= PW_MAX) &&
               ((mode == MODE_WRAP) || (mode == MODE_SAT));
    endfunction

endpackage

// File: rtl/rt_prog_cnt_if.sv
// rt_prog_cnt_if: control/status bundle of rt_prog_cnt.
//   Inputs to the counter : rt_i_clr, rt_i_ce, rt_i_dir, rt_i_ld, rt_i_ld_val,
//                           rt_i_max, rt_i_psc, rt_i_cap, rt_i_ovf_clr
//   Outputs of the counter: rt_o_cnt, rt_o_tc, rt_o_ovf, rt_o_cap, rt_o_cap_vld
//   master = the block driving the counter, slave = the counter itself.
interface rt_prog_cnt_if #(
    parameter int CW = 32,
    parameter int PW = 8
) ();
    logic          rt_i_clr;
    logic          rt_i_ce;
    logic          rt_i_dir;
    logic          rt_i_ld;
    logic [CW-1:0] rt_i_ld_val;
    logic [CW-1:0] rt_i_max;
    logic [PW-1:0] rt_i_psc;
    logic          rt_i_cap;
    logic          rt_i_ovf_clr;

    logic [CW-1:0] rt_o_cnt;
    logic          rt_o_tc;
    logic          rt_o_ovf;
    logic [CW-1:0] rt_o_cap;
    logic          rt_o_cap_vld;

    modport master (
        output rt_i_clr, rt_i_ce, rt_i_dir, rt_i_ld, rt_i_ld_val,
               rt_i_max, rt_i_psc, rt_i_cap, rt_i_ovf_clr,
        input  rt_o_cnt, rt_o_tc, rt_o_ovf, rt_o_cap, rt_o_cap_vld
    );

    modport slave (
        input  rt_i_clr, rt_i_ce, rt_i_dir, rt_i_ld, rt_i_ld_val,
               rt_i_max, rt_i_psc, rt_i_cap, rt_i_ovf_clr,
        output rt_o_cnt, rt_o_tc, rt_o_ovf, rt_o_cap, rt_o_cap_vld
    );
endinterface

// File: rtl/rt_prog_cnt_psc_tick.sv
// rt_psc_tick: clock-enable prescaler.
//   clk_i, rst_ni : clock, async active-low reset
//   ce_i          : count enable; each enabled cycle advances the prescaler
//   clr_i, ld_i   : sync clear/load of the parent counter; both zero the prescaler
//   psc_i         : one tick every (psc_i+1) enabled cycles
//   tick_o        : combinational step strobe for the parent counter
module rt_psc_tick #(
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          ce_i,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic [PW-1:0] psc_i,
    output logic          tick_o
);

    logic [PW-1:0] psc_cnt_q, psc_cnt_d;

    // clr/ld suppress the step, so a load is never overwritten in the same cycle.
    assign tick_o = ce_i & (psc_cnt_q == psc_i) & ~clr_i & ~ld_i;

    // If psc_i is lowered below psc_cnt_q the counter simply runs on and
    // wraps through 2^PW before matching again; no forced resync.
    always_comb begin
        psc_cnt_d = psc_cnt_q;
        if (clr_i || ld_i)  psc_cnt_d = '0;
        else if (tick_o)    psc_cnt_d = '0;
        else if (ce_i)      psc_cnt_d = psc_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) psc_cnt_q <= '0;
        else         psc_cnt_q <= psc_cnt_d;
    end

endmodule

// File: rtl/rt_prog_cnt.sv
// rt_prog_cnt: programmable up/down event counter.
//   rt_i_clk, rt_i_rst_n : clock, async active-low reset
//   bus (slave)          : clr/ce/dir/ld/ld_val/max/psc/cap/ovf_clr in,
//                          cnt/tc/ovf/cap/cap_vld out (all outputs registered)
//   CW       counter width, PW prescaler width, SAT_MODE wrap(0)/saturate(1).
module rt_prog_cnt
    import rt_cnt_pkg::*;
#(
    parameter int CW       = 32,
    parameter int PW       = 8,
    parameter int SAT_MODE = MODE_WRAP
) (
    input  logic         rt_i_clk,
    input  logic         rt_i_rst_n,
    rt_prog_cnt_if.slave bus
);

    localparam bit SAT = (SAT_MODE == MODE_SAT);

    generate
        if (!rt_params_ok(CW, PW, SAT_MODE)) begin : g_bad_param
            $error("rt_prog_cnt: CW/PW/SAT_MODE out of range");
        end
    endgenerate

    logic          tick;
    logic          bnd;
    logic [CW-1:0] step_v;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tc_q, tc_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cap_q;
    logic          cap_vld_q;

    rt_psc_tick #(.PW(PW)) u_psc (
        .clk_i  (rt_i_clk),
        .rst_ni (rt_i_rst_n),
        .ce_i   (bus.rt_i_ce),
        .clr_i  (bus.rt_i_clr),
        .ld_i   (bus.rt_i_ld),
        .psc_i  (bus.rt_i_psc),
        .tick_o (tick)
    );

    always_comb begin
        // Up uses >= so a loaded value above max still treats the next step as boundary.
        if (bus.rt_i_dir == DIR_UP) begin
            bnd    = (cnt_q >= bus.rt_i_max);
            step_v = bnd ? (SAT ? bus.rt_i_max : '0) : cnt_q + 1'b1;
        end else begin
            bnd    = (cnt_q == '0);
            step_v = bnd ? (SAT ? '0 : bus.rt_i_max) : cnt_q - 1'b1;
        end

        cnt_d = cnt_q;
        if (bus.rt_i_clr)     cnt_d = '0;
        else if (bus.rt_i_ld) cnt_d = bus.rt_i_ld_val;
        else if (tick)        cnt_d = step_v;

        // tick is already masked by clr/ld, so tc never fires on a clear or load.
        tc_d = tick & bnd;

        ovf_d = ovf_q;
        if (bus.rt_i_clr)          ovf_d = 1'b0;
        else if (tc_d)             ovf_d = 1'b1;
        else if (bus.rt_i_ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge rt_i_clk or negedge rt_i_rst_n) begin
        if (!rt_i_rst_n) begin
            cnt_q     <= '0;
            tc_q      <= 1'b0;
            ovf_q     <= 1'b0;
            cap_q     <= '0;
            cap_vld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tc_q      <= tc_d;
            ovf_q     <= ovf_d;
            // Snapshot takes the pre-update count, even alongside clr/ld.
            if (bus.rt_i_cap) cap_q <= cnt_q;
            cap_vld_q <= bus.rt_i_cap;
        end
    end

    assign bus.rt_o_cnt     = cnt_q;
    assign bus.rt_o_tc      = tc_q;
    assign bus.rt_o_ovf     = ovf_q;
    assign bus.rt_o_cap     = cap_q;
    assign bus.rt_o_cap_vld = cap_vld_q;

endmodule

// File: tb/tb_rt_prog_cnt.sv
// Bench for rt_prog_cnt: a wrap instance and a saturate instance share one
// stimulus stream; both are compared each cycle against a behavioural model,
// with directed scenarios plus constant spot checks and a random phase.
module tb_rt_prog_cnt;
    import rt_cnt_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 0, ce = 0, dir = 1, ld = 0, cap = 0, ovf_clr = 0;
    logic [31:0] ld_val = 0, max_v = 32'hFFFF_FFFF;
    logic [7:0]  psc = 0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rt_prog_cnt_if #(.CW(32), .PW(8)) if0 ();
    rt_prog_cnt_if #(.CW(32), .PW(8)) if1 ();

    assign if0.rt_i_clr = clr;   assign if1.rt_i_clr = clr;
    assign if0.rt_i_ce  = ce;    assign if1.rt_i_ce  = ce;
    assign if0.rt_i_dir = dir;   assign if1.rt_i_dir = dir;
    assign if0.rt_i_ld  = ld;    assign if1.rt_i_ld  = ld;
    assign if0.rt_i_ld_val = ld_val;  assign if1.rt_i_ld_val = ld_val;
    assign if0.rt_i_max = max_v; assign if1.rt_i_max = max_v;
    assign if0.rt_i_psc = psc;   assign if1.rt_i_psc = psc;
    assign if0.rt_i_cap = cap;   assign if1.rt_i_cap = cap;
    assign if0.rt_i_ovf_clr = ovf_clr; assign if1.rt_i_ovf_clr = ovf_clr;

    rt_prog_cnt #(.CW(32), .PW(8), .SAT_MODE(MODE_WRAP)) u_wrap (
        .rt_i_clk(clk), .rt_i_rst_n(rst_n), .bus(if0.slave));
    rt_prog_cnt #(.CW(32), .PW(8), .SAT_MODE(MODE_SAT)) u_sat (
        .rt_i_clk(clk), .rt_i_rst_n(rst_n), .bus(if1.slave));

    logic [31:0] d_cnt [2], d_cap [2];
    logic        d_tc [2], d_ovf [2], d_cv [2];
    assign d_cnt[0] = if0.rt_o_cnt; assign d_cnt[1] = if1.rt_o_cnt;
    assign d_cap[0] = if0.rt_o_cap; assign d_cap[1] = if1.rt_o_cap;
    assign d_tc[0]  = if0.rt_o_tc;  assign d_tc[1]  = if1.rt_o_tc;
    assign d_ovf[0] = if0.rt_o_ovf; assign d_ovf[1] = if1.rt_o_ovf;
    assign d_cv[0]  = if0.rt_o_cap_vld; assign d_cv[1] = if1.rt_o_cap_vld;

    // Reference model state, index 0 = wrap, 1 = saturate.
    logic [31:0] m_cnt [2], m_cap [2];
    logic [7:0]  m_psc [2];
    bit          m_tc [2], m_ovf [2], m_cv [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_cap[i] = 0; m_psc[i] = 0;
            m_tc[i] = 0; m_ovf[i] = 0; m_cv[i] = 0;
        end
    endtask

    // One clock of the counter rules, evaluated from the inputs present at the edge.
    task automatic m_step();
        for (int i = 0; i < 2; i++) begin
            bit sat = (i == 1);
            bit tk  = ce && (m_psc[i] == psc) && !clr && !ld;
            bit at_edge = dir ? (m_cnt[i] >= max_v) : (m_cnt[i] == 0);
            bit hit = tk && at_edge;
            if (cap) m_cap[i] = m_cnt[i];
            m_cv[i] = cap;
            if (clr || ld || tk) m_psc[i] = 0;
            else if (ce)         m_psc[i] = m_psc[i] + 8'd1;
            if (clr)      m_cnt[i] = 0;
            else if (ld)  m_cnt[i] = ld_val;
            else if (tk) begin
                if (hit) m_cnt[i] = (dir == sat) ? max_v : 32'd0;
                else     m_cnt[i] = dir ? m_cnt[i] + 32'd1 : m_cnt[i] - 32'd1;
            end
            m_tc[i] = hit;
            if (clr)          m_ovf[i] = 0;
            else if (hit)     m_ovf[i] = 1;
            else if (ovf_clr) m_ovf[i] = 0;
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("cnt[%0d]", i), 64'(d_cnt[i]), 64'(m_cnt[i]));
            chk($sformatf("tc[%0d]", i),  64'(d_tc[i]),  64'(m_tc[i]));
            chk($sformatf("ovf[%0d]", i), 64'(d_ovf[i]), 64'(m_ovf[i]));
            chk($sformatf("cap[%0d]", i), 64'(d_cap[i]), 64'(m_cap[i]));
            chk($sformatf("capv[%0d]", i), 64'(d_cv[i]), 64'(m_cv[i]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        m_step();
        #1;
        cmp_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        m_reset();
        #1;
        cmp_all();
        chk("rst_cnt", 64'(if0.rt_o_cnt), 64'd0);
        #11;
        rst_n = 1'b1;

        // 1: free run from reset
        ce = 1; dir = 1; psc = 0; max_v = 32'hFFFF_FFFF;
        steps(10);
        chk("t1_cnt", 64'(if0.rt_o_cnt), 64'd10);
        chk("t1_ovf", 64'(if0.rt_o_ovf), 64'd0);

        // 2: wrap at all-ones
        ld_val = 32'hFFFF_FFFE; ld = 1;
        step();
        ld = 0;
        step();
        chk("t2_ff", 64'(if0.rt_o_cnt), 64'hFFFF_FFFF);
        step();
        chk("t2_wrap", 64'(if0.rt_o_cnt), 64'd0);
        chk("t2_tc", 64'(if0.rt_o_tc), 64'd1);
        step();
        chk("t2_ovf_sticky", 64'(if0.rt_o_ovf), 64'd1);
        chk("t2_tc_once", 64'(if0.rt_o_tc), 64'd0);

        // 3: modulo-10 down count, ovf_clr colliding with a boundary step
        max_v = 9; dir = 0; ld_val = 1; ld = 1; ovf_clr = 1;
        step();
        ld = 0; ovf_clr = 0;
        chk("t3_ovf_cleared", 64'(if0.rt_o_ovf), 64'd0);
        step();
        chk("t3_zero", 64'(if0.rt_o_cnt), 64'd0);
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        chk("t3_wrap9", 64'(if0.rt_o_cnt), 64'd9);
        chk("t3_tc", 64'(if0.rt_o_tc), 64'd1);
        chk("t3_ovf_wins", 64'(if0.rt_o_ovf), 64'd1);
        step();
        chk("t3_eight", 64'(if0.rt_o_cnt), 64'd8);

        // 4: saturate at max=5
        max_v = 5; dir = 1; ld_val = 3; ld = 1;
        step();
        ld = 0;
        steps(2);
        chk("t4_five", 64'(if1.rt_o_cnt), 64'd5);
        step();
        chk("t4_hold", 64'(if1.rt_o_cnt), 64'd5);
        chk("t4_tc", 64'(if1.rt_o_tc), 64'd1);
        step();
        chk("t4_tc_again", 64'(if1.rt_o_tc), 64'd1);

        // 5: prescale by 4
        max_v = 32'hFFFF_FFFF; clr = 1; psc = 3;
        step();
        clr = 0;
        steps(40);
        chk("t5_psc", 64'(if0.rt_o_cnt), 64'd10);
        for (int k = 0; k < 16; k++) begin
            ce = k[0];
            step();
        end
        chk("t5_gated", 64'(if0.rt_o_cnt), 64'd12);
        ce = 1; psc = 0;

        // 6: capture alongside clear
        ld_val = 7; ld = 1;
        step();
        ld = 0; ce = 0; cap = 1; clr = 1;
        step();
        cap = 0; clr = 0;
        chk("t6_cap", 64'(if0.rt_o_cap), 64'd7);
        chk("t6_capv", 64'(if0.rt_o_cap_vld), 64'd1);
        chk("t6_cnt", 64'(if0.rt_o_cnt), 64'd0);
        step();
        chk("t6_capv_off", 64'(if0.rt_o_cap_vld), 64'd0);

        // Random phase with small terminal values so boundaries are frequent.
        for (int k = 0; k < 600; k++) begin
            clr     = ($urandom_range(0, 39) == 0);
            ld      = ($urandom_range(0, 24) == 0);
            ce      = ($urandom_range(0, 3) != 0);
            dir     = $urandom_range(0, 1);
            cap     = ($urandom_range(0, 4) == 0);
            ovf_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) max_v = $urandom_range(0, 20);
            if ($urandom_range(0, 79) == 0) psc = 8'($urandom_range(0, 3));
            ld_val = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 25));
            step();
            if (k == 300) begin
                // async reset between edges; outputs must drop without a clock
                #2 rst_n = 1'b0;
                #1;
                m_reset();
                cmp_all();
                #1 rst_n = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
